execute_pipe: RTL

- Parametrised, registered successor to the single-cycle execute stage, sitting between decode/operand-fetch and memory.
- Computes the ALU result, the branch/jump decision ("leap") and the leap target address.
- Adds a multi-cycle iterative multiplier and valid/ready handshakes on both sides.
- Adds a flush input, and sign-extends branch/jump offsets (the previous stage zero-extended them).

---
 rtl/exec_pkg.sv | 49 ++++
 rtl/mul_iter.sv | 83 ++++++++
 rtl/execute_pipe.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared constants and helpers for the execute stage
//
// Purpose: ALU opcode values, sideband field positions, the branch/jump
//          offset sign-extender and the shift-amount width helper used by
//          execute_pipe and its multiplier.
// Ports:   none (package).

package exec_pkg;

  // ALU operation codes carried on ALUCtrl_in
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_LHI   = 4'd10;
  localparam logic [3:0] ALU_PASSB = 4'd11;

  // Sideband bit positions (the stage passes the bus through untouched)
  localparam int SB_REGWRITE = 0;
  localparam int SB_MEMTOREG = 1;
  localparam int SB_MEMWRITE = 2;
  localparam int SB_LOADSIGN = 3;
  localparam int SB_PCTOREG  = 4;
  localparam int SB_DSIZE_LO = 5;
  localparam int SB_DSIZE_HI = 6;

  // Width of the sign-extended offset; callers keep the low DATA_W bits.
  localparam int OFF_EXT_W = 64;

  // Number of low operand-B bits used as a shift amount.
  function automatic int shift_w(input int data_w);
    return $clog2(data_w);
  endfunction

  // Branches use the 16-bit offset, jumps the 26-bit one; both are signed.
  function automatic logic [OFF_EXT_W-1:0] sext_offset(input logic        use16,
                                                       input logic [15:0] off16,
                                                       input logic [25:0] off26);
    if (use16) return {{(OFF_EXT_W-16){off16[15]}}, off16};
    return {{(OFF_EXT_W-26){off26[25]}}, off26};
  endfunction

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier, MUL_BITS per cycle
//
// Purpose: low DATA_W bits of a_i * b_i computed over DATA_W/MUL_BITS
//          cycles. Low product bits are the same for signed and unsigned
//          operands, so no sign handling is needed.
// Ports:   clk, rst_n     clock, async active-low reset
//          start_i        load operands and begin (ignored while aborting)
//          abort_i        drop the operation in flight
//          a_i, b_i       multiplicand, multiplier
//          busy_o         an operation is in flight
//          done_o         this edge retires the last step
//          product_o      product value written at the done edge

module mul_iter #(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int N     = DATA_W / MUL_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (abort_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      cnt_d    = N_CNT;
    end else if (cnt_q != '0) begin
      // Multiplicand moves left and multiplier right, so bit i of the
      // multiplier always pairs with mcand << i.
      for (int i = 0; i < MUL_BITS; i++) begin
        if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
      end
      mcand_d  = mcand_q << MUL_BITS;
      mplier_d = mplier_q >> MUL_BITS;
      cnt_d    = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy_o    = (cnt_q != '0);
  // product_o is the accumulator after this cycle's step, so the owner can
  // register it on the same edge the counter reaches zero.
  assign done_o    = (cnt_q == ONE) && !abort_i;
  assign product_o = acc_d;

endmodule

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - registered execute stage with ALU, leap and multiplier
//
// Purpose: computes the ALU result, the branch/jump decision (leap) and its
//          target; multiplies run through mul_iter. Valid/ready on both sides.
// Ports:   clk, reset                 clock, async active-low reset
//          in_valid/in_ready          upstream handshake
//          flush                      kill in-flight and held work
//          nextPC_in, opA_in, opB_in  PC+4 and operands
//          offset26_in, offset16_in   jump / branch offsets (signed)
//          destReg_in, ALUCtrl_in     destination, ALU op
//          mul_in, jump_in, branch_in, branchZero_in, RegToPC_in  op kind
//          sb_in                      sideband, passed through
//          out_valid/out_ready        downstream handshake
//          aluResult_out, of_out, leap_out, leapAddr_out, nextPC_out,
//          destReg_out, sb_out        registered results

module execute_pipe
  import exec_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 1,
  parameter int SB_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] nextPC_in,
  input  logic [DATA_W-1:0] opA_in,
  input  logic [DATA_W-1:0] opB_in,
  input  logic [25:0]       offset26_in,
  input  logic [15:0]       offset16_in,
  input  logic [4:0]        destReg_in,
  input  logic [3:0]        ALUCtrl_in,
  input  logic              mul_in,
  input  logic              jump_in,
  input  logic              branch_in,
  input  logic              branchZero_in,
  input  logic              RegToPC_in,
  input  logic [SB_W-1:0]   sb_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] aluResult_out,
  output logic              of_out,
  output logic              leap_out,
  output logic [DATA_W-1:0] leapAddr_out,
  output logic [DATA_W-1:0] nextPC_out,
  output logic [4:0]        destReg_out,
  output logic [SB_W-1:0]   sb_out
);

  localparam int SH_W = shift_w(DATA_W);

  typedef enum logic {S_RUN, S_MUL} state_e;

  state_e            state_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] result_q;
  logic              of_q;
  logic              leap_q;
  logic [DATA_W-1:0] leap_addr_q;
  logic [DATA_W-1:0] next_pc_q;
  logic [4:0]        dest_q;
  logic [SB_W-1:0]   sb_q;

  logic              accept;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_res;
  logic              alu_of;

  logic                 leap;
  logic [OFF_EXT_W-1:0] off_ext;
  logic [DATA_W-1:0]    leap_addr;

  assign in_ready = !flush && (state_q == S_RUN) && !mul_busy &&
                    (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // ALU
  assign shamt = opB_in[SH_W-1:0];
  assign sum   = opA_in + opB_in;
  assign diff  = opA_in - opB_in;

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (ALUCtrl_in)
      ALU_ADD: begin
        alu_res = sum;
        alu_of  = (opA_in[DATA_W-1] == opB_in[DATA_W-1]) &&
                  (sum[DATA_W-1] != opA_in[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_of  = (opA_in[DATA_W-1] != opB_in[DATA_W-1]) &&
                  (diff[DATA_W-1] != opA_in[DATA_W-1]);
      end
      ALU_AND:   alu_res = opA_in & opB_in;
      ALU_OR:    alu_res = opA_in | opB_in;
      ALU_XOR:   alu_res = opA_in ^ opB_in;
      ALU_SLL:   alu_res = opA_in << shamt;
      ALU_SRL:   alu_res = opA_in >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(opA_in) >>> shamt);
      ALU_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(opA_in) < $signed(opB_in))};
      ALU_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (opA_in < opB_in)};
      ALU_LHI:   alu_res = opB_in << 16;
      ALU_PASSB: alu_res = opB_in;
      default: begin
        alu_res = '0;
        alu_of  = 1'b0;
      end
    endcase
  end

  // Leap decision and target; the target is produced even when not taken.
  assign leap      = jump_in || (branch_in && (branchZero_in == (opA_in == '0)));
  assign off_ext   = sext_offset(branch_in, offset16_in, offset26_in);
  assign leap_addr = RegToPC_in ? opA_in : (nextPC_in + off_ext[DATA_W-1:0]);

  mul_iter #(
    .DATA_W  (DATA_W),
    .MUL_BITS(MUL_BITS)
  ) u_mul (
    .clk      (clk),
    .rst_n    (reset),
    .start_i  (accept && mul_in),
    .abort_i  (flush),
    .a_i      (opA_in),
    .b_i      (opB_in),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      of_q        <= 1'b0;
      leap_q      <= 1'b0;
      leap_addr_q <= '0;
      next_pc_q   <= '0;
      dest_q      <= '0;
      sb_q        <= '0;
    end else if (flush) begin
      state_q     <= S_RUN;
      out_valid_q <= 1'b0;
    end else begin
      if (out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (accept) begin
            next_pc_q   <= nextPC_in;
            dest_q      <= destReg_in;
            sb_q        <= sb_in;
            leap_addr_q <= leap_addr;
            if (mul_in) begin
              // Pass-through fields are parked in the output registers; the
              // product lands on the done edge with out_valid.
              state_q <= S_MUL;
              of_q    <= 1'b0;
              leap_q  <= 1'b0;
            end else begin
              result_q    <= alu_res;
              of_q        <= alu_of;
              leap_q      <= leap;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            result_q    <= mul_product;
            of_q        <= 1'b0;
            leap_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_RUN;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign aluResult_out = result_q;
  assign of_out        = of_q;
  assign leap_out      = leap_q;
  assign leapAddr_out  = leap_addr_q;
  assign nextPC_out    = next_pc_q;
  assign destReg_out   = dest_q;
  assign sb_out        = sb_q;

endmodule
